pulse_generator: RTL and testbench
==================================

PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning bit width of the length inputs and internal counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port trigger  input  1  one-cycle start request, typically a posedge-detector output.
REQ-005 SHALL have port pulse_len  input  CNT_W  high-time in cycles, sampled at trigger acceptance.
REQ-006 SHALL have port gap_len  input  CNT_W  mandatory low-time after the pulse in cycles, sampled at acceptance.
REQ-007 SHALL have port pulse_out  output  1  registered generated pulse.
REQ-008 SHALL have port busy  output  1  registered; high while a pulse or gap is in progress.
REQ-009 SHALL have port done  output  1  registered one-cycle strobe at pulse end.
REQ-010 SHALL have port overrun  output  1  registered one-cycle strobe when a trigger is rejected.

Function
REQ-011 SHALL implement states IDLE, HIGH, GAP; only IDLE accepts a trigger.
REQ-012 Trigger in IDLE at cycle N with pulse_len=L>0 SHALL give pulse_out=1 in cycles N+1..N+L, busy=1 from N+1.
REQ-013 pulse_len and gap_len SHALL be latched at acceptance; later input changes do not affect the current pulse.
REQ-014 HIGH->GAP after L cycles; done=1 in cycle N+L+1, the first low cycle.
REQ-015 GAP SHALL last gap_len=G cycles (N+L+1..N+L+G) with pulse_out=0, busy=1; then IDLE, busy=0 at N+L+G+1.
REQ-016 G=0: HIGH->IDLE directly; busy=0 in cycle N+L+1, concurrently with done=1.
REQ-017 L=0 trigger: accepted, pulse_out stays 0, done=1 at N+1, then GAP for G cycles (IDLE if G=0).
REQ-018 Trigger in the cycle busy falls SHALL be accepted (state already IDLE); back-to-back pulses then separated by exactly G low cycles.
REQ-019 Max length 2^CNT_W-1 cycles; counter SHALL NOT wrap (down-counter, terminates at 1).
REQ-020 done and overrun SHALL be single-cycle, never asserted two consecutive cycles for one event.

Reset
REQ-021 rst=1 at any rising edge SHALL force IDLE, pulse_out=0, busy=0, done=0, overrun=0, counter=0, including mid-pulse (no done emitted).
REQ-022 trigger coincident with rst SHALL be ignored; first acceptable trigger is the cycle after rst deasserts.

Configuration
REQ-023 Macro PULSE_GENERATOR_RETRIGGER_EN defined: trigger in HIGH SHALL reload counter with the current pulse_len, extending the pulse with no low glitch, no overrun; trigger in GAP SHALL be rejected with overrun=1 next cycle.
REQ-024 Macro undefined: any trigger while busy (HIGH or GAP) SHALL be dropped with overrun=1 the next cycle; pulse timing unaffected.

Structure
REQ-025 Package pulse_generator_pkg SHALL hold the state encoding constants (IDLE=2'd0, HIGH=2'd1, GAP=2'd2) and default CNT_W.
REQ-026 Sub-module pulse_down_counter (load, load_val, en, zero flag) SHALL implement the shared HIGH/GAP counter.
REQ-027 Unused state encoding 2'd3 SHALL recover to IDLE next cycle.

Verification
REQ-028 L=3, G=2, trigger at cycle 10 -> pulse_out 11..13, done at 14, busy 11..15, busy=0 at 16.
REQ-029 L=4, G=0, triggers at 10 and 15 -> pulses 11..14 and 16..19, done at 15 and 20, no overrun.
REQ-030 L=5, G=3, trigger at 10, second at 12: macro off -> overrun at 13, pulse ends 15; macro on -> pulse_out 11..17, done at 18.
REQ-031 L=0, G=1, trigger at 10 -> pulse_out never high, done at 11, busy 11 only.
REQ-032 L=8, trigger at 10, rst at 13 -> all outputs 0 from 14, no done; trigger at 14 -> accepted, pulse from 15.
REQ-033 CNT_W=8, L=255, G=0 -> pulse_out exactly 255 cycles, no wrap, single done.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// Shared definitions for the pulse generator: state encoding and default
// counter width.
package pulse_generator_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage : pulse_generator_pkg

// File: rtl/pulse_down_counter.sv
// Loadable saturating down-counter shared by the HIGH and GAP phases.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears the count
//   i_load     - load i_load_val (priority over i_en)
//   i_load_val - value to load
//   i_en       - decrement by one; holds at zero
//   o_count    - current count
//   o_zero     - count is zero
module pulse_down_counter
  import pulse_generator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Saturate at zero so the count can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : pulse_down_counter

// File: rtl/pulse_generator.sv
// Trigger-started pulse generator: emits pulse_len cycles high followed by a
// mandatory gap_len-cycle low period, with done/overrun strobes.
// Build option: define PULSE_GENERATOR_RETRIGGER_EN to let a trigger during
// the high phase restart the high time with the current pulse_len.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   trigger   - one-cycle start request
//   pulse_len - high time in cycles, sampled on acceptance
//   gap_len   - low time after the pulse in cycles, sampled on acceptance
//   pulse_out - registered pulse
//   busy      - registered, high during the pulse and the gap
//   done      - registered one-cycle strobe in the first low cycle
//   overrun   - registered one-cycle strobe after a rejected trigger
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] gap_len,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_last;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_en;
  logic             w_accept;
  logic             w_retrig;
  logic             w_done;
  logic             w_overrun;

  pulse_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_count    (w_cnt),
    .o_zero     (w_zero)
  );

  // The count holds the cycles remaining in the current phase, including
  // this one; a zero count is treated as last so a phase can never stall.
  assign w_last = (w_cnt == CNT_W'(1)) || w_zero;

  // Next-state, counter control and strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_en         = 1'b0;
    w_accept     = 1'b0;
    w_retrig     = 1'b0;
    w_done       = 1'b0;
    w_overrun    = 1'b0;

    case (r_state)
      IDLE: begin
        if (trigger) begin
          w_accept = 1'b1;
          if (pulse_len != '0) begin
            w_next_state = HIGH;
            w_load       = 1'b1;
            w_load_val   = pulse_len;
          end else begin
            // Zero-length pulse: finish immediately, still honour the gap.
            w_done = 1'b1;
            if (gap_len != '0) begin
              w_next_state = GAP;
              w_load       = 1'b1;
              w_load_val   = gap_len;
            end
          end
        end
      end

      HIGH: begin
`ifdef PULSE_GENERATOR_RETRIGGER_EN
        // A zero pulse_len on a retrigger leaves the running pulse untouched.
        if (trigger && (pulse_len != '0)) begin
          w_retrig = 1'b1;
        end
`else
        if (trigger) begin
          w_overrun = 1'b1;
        end
`endif
        if (w_retrig) begin
          w_load     = 1'b1;
          w_load_val = pulse_len;
        end else if (w_last) begin
          w_done = 1'b1;
          if (r_gap != '0) begin
            w_next_state = GAP;
            w_load       = 1'b1;
            w_load_val   = r_gap;
          end else begin
            w_next_state = IDLE;
            w_en         = 1'b1;
          end
        end else begin
          w_en = 1'b1;
        end
      end

      GAP: begin
        if (trigger) begin
          w_overrun = 1'b1;
        end
        w_en = 1'b1;
        if (w_last) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gap     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      pulse_out <= (w_next_state == HIGH);
      busy      <= (w_next_state != IDLE);
      done      <= w_done;
      overrun   <= w_overrun;
      if (w_accept) begin
        r_gap <= gap_len;
      end
    end
  end

endmodule : pulse_generator

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: directed scenarios followed by
// random traffic, all compared against an event-time reference model.
module tb_pulse_generator;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] gap_len;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             overrun;

  pulse_generator #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .pulse_len (pulse_len),
    .gap_len   (gap_len),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Reference model: absolute cycle numbers of the current pulse's events.
  longint m_bstart;   // first busy / high cycle
  longint m_hend;     // last high cycle
  longint m_bend;     // last busy cycle
  longint m_done;     // done strobe cycle
  longint m_ovr;      // overrun strobe cycle
  int     m_glat;     // latched gap length
  int     n_high;
  int     n_done;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bstart = 64'sd1 <<< 50;
    m_hend   = -10;
    m_bend   = -10;
    m_done   = -10;
    m_ovr    = -10;
    m_glat   = 0;
  endtask

  // Apply the inputs sampled at the end of cycle c.
  task automatic model_step(input longint c, input logic r, input logic t,
                            input int pl, input int gl);
    if (r) begin
      model_reset();
    end else if (t) begin
      if (c > m_bend) begin
        m_bstart = c + 1;
        m_hend   = c + pl;
        m_done   = c + pl + 1;
        m_bend   = c + pl + gl;
        m_glat   = gl;
      end else begin
`ifdef PULSE_GENERATOR_RETRIGGER_EN
        if (c <= m_hend) begin
          if (pl != 0) begin
            m_hend = c + pl;
            m_done = c + pl + 1;
            m_bend = c + pl + m_glat;
          end
        end else begin
          m_ovr = c + 1;
        end
`else
        m_ovr = c + 1;
`endif
      end
    end
  endtask

  task automatic step(input logic r, input logic t, input int pl, input int gl);
    @(negedge clk);
    rst       = r;
    trigger   = t;
    pulse_len = CNT_W'(pl);
    gap_len   = CNT_W'(gl);
    @(posedge clk);
    model_step(cyc, r, t, pl, gl);
    cyc++;
    #1;
    check("pulse_out", pulse_out, (cyc >= m_bstart) && (cyc <= m_hend));
    check("busy",      busy,      (cyc >= m_bstart) && (cyc <= m_bend));
    check("done",      done,      cyc == m_done);
    check("overrun",   overrun,   cyc == m_ovr);
    n_high += int'(pulse_out === 1'b1);
    n_done += int'(done === 1'b1);
  endtask

  // Quiet cycles with random length inputs, which must not affect a pulse.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst       = 1'b1;
    trigger   = 1'b0;
    pulse_len = '0;
    gap_len   = '0;
    n_high    = 0;
    n_done    = 0;
    model_reset();

    // Reset, including a trigger coincident with reset.
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 5, 5);
    idle(3);

    // L=3, G=2.
    step(1'b0, 1'b1, 3, 2);
    idle(8);

    // L=4, G=0, second trigger in the cycle busy falls.
    step(1'b0, 1'b1, 4, 0);
    idle(4);
    step(1'b0, 1'b1, 4, 0);
    idle(6);

    // L=5, G=3, trigger two cycles into the pulse, then one in the gap.
    step(1'b0, 1'b1, 5, 3);
    idle(1);
    step(1'b0, 1'b1, 5, 3);
    idle(5);
    step(1'b0, 1'b1, 2, 2);
    idle(8);

    // L=0, G=1 and L=0, G=0.
    step(1'b0, 1'b1, 0, 1);
    idle(3);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 2, 0);
    idle(4);

    // Reset mid-pulse, then an immediate new trigger.
    step(1'b0, 1'b1, 8, 0);
    idle(2);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 8, 0);
    idle(10);

    // Maximum length pulse: exactly 255 high cycles and one done.
    n_high = 0;
    n_done = 0;
    step(1'b0, 1'b1, 255, 0);
    idle(262);
    check("len255_high_count", n_high == 255, 1'b1);
    check("len255_done_count", n_done == 1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 12)),
           int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_generator
